// File: rtl/threshold_monitor_pkg.sv
// Shared types and widths for the threshold monitor.
package threshold_monitor_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    TRIPPED  = 2'b10
  } mon_state_t;

endpackage

// File: rtl/threshold_monitor_ule_cmp8.sv
// Unsigned A <= B, taken as the carry-out of B + ~A + 1 through an explicit ripple chain.
module ule_cmp8
  import threshold_monitor_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              O
);

  logic [DATA_W-1:0] a_n;
  logic [DATA_W:0]   carry;

  assign a_n      = ~A;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DATA_W; i++) begin : g_chain
    assign carry[i+1] = (B[i] & a_n[i]) | (carry[i] & (B[i] ^ a_n[i]));
  end

  assign O = carry[DATA_W];

endmodule

// File: rtl/threshold_monitor.sv
// Counts consecutive samples at or below a programmable threshold and raises a sticky alarm.
//   state    | meaning
//   IDLE     | no qualifying run in progress, COUNT=0
//   COUNTING | 0 < COUNT < N_HITS consecutive hits seen
//   TRIPPED  | COUNT=N_HITS, ALARM held until ACK
module threshold_monitor
  import threshold_monitor_pkg::*;
#(
  parameter int N_HITS = 4
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              LOAD,
  input  logic [DATA_W-1:0] THRESH,
  input  logic              VALID,
  input  logic [DATA_W-1:0] DATA,
  input  logic              ACK,
  output logic              HIT,
  output logic              ALARM,
  output logic [CNT_W-1:0]  COUNT
);

  localparam logic [CNT_W-1:0] N_HITS_C = CNT_W'(N_HITS);

  mon_state_t        state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [CNT_W-1:0]  count_inc;
  logic [DATA_W-1:0] thresh_q;
  logic              hit_q;
  logic              cmp_le;

  ule_cmp8 u_cmp (
    .A (DATA),
    .B (thresh_q),
    .O (cmp_le)
  );

  assign count_inc = count + 1'b1;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state    <= IDLE;
      count    <= '0;
      thresh_q <= '1;
      hit_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (LOAD)  thresh_q <= THRESH;
      if (VALID) hit_q    <= cmp_le;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE, COUNTING: begin
        // LOAD restarts the run even if a sample hits in the same cycle
        if (LOAD) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (VALID) begin
          if (cmp_le) begin
            count_nxt = count_inc;
            state_nxt = (count_inc == N_HITS_C) ? TRIPPED : COUNTING;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      TRIPPED: begin
        if (ACK) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign HIT   = hit_q;
  assign ALARM = (state == TRIPPED);
  assign COUNT = count;

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed bench for threshold_monitor; a second instance with N_HITS=1 covers the single-hit trip.
module tb_threshold_monitor;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] THRESH = 8'h00;
  logic       VALID = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic       ACK = 1'b0;
  logic       HIT, ALARM;
  logic [3:0] COUNT;
  logic       hit1, alarm1;
  logic [3:0] count1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  threshold_monitor #(.N_HITS(4)) dut (
    .CLK(CLK), .RESETN(RESETN), .LOAD(LOAD), .THRESH(THRESH), .VALID(VALID),
    .DATA(DATA), .ACK(ACK), .HIT(HIT), .ALARM(ALARM), .COUNT(COUNT)
  );

  threshold_monitor #(.N_HITS(1)) dut1 (
    .CLK(CLK), .RESETN(RESETN), .LOAD(LOAD), .THRESH(THRESH), .VALID(VALID),
    .DATA(DATA), .ACK(ACK), .HIT(hit1), .ALARM(alarm1), .COUNT(count1)
  );

  // one clock of stimulus; inputs return to idle 1ns after the edge
  task automatic step(input logic rn, input logic ld, input logic [7:0] th,
                      input logic v, input logic [7:0] d, input logic ak);
    RESETN = rn; LOAD = ld; THRESH = th; VALID = v; DATA = d; ACK = ak;
    @(posedge CLK);
    #1;
    RESETN = 1'b1; LOAD = 1'b0; VALID = 1'b0; ACK = 1'b0;
  endtask

  task automatic sample(input logic [7:0] d);
    step(1'b1, 1'b0, 8'h00, 1'b1, d, 1'b0);
  endtask

  task automatic idle_cycle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
    checks++;
    if (HIT !== 1'b0 || COUNT !== 4'd0 || ALARM !== 1'b0) begin
      errors++;
      $display("FAIL reset: hit=%b count=%0d alarm=%b, expected 0 0 0", HIT, COUNT, ALARM);
    end
  endtask

  task automatic test_default_thresh();
    for (int i = 1; i <= 3; i++) begin
      sample(8'hFF);
      checks++;
      if (HIT !== 1'b1 || COUNT !== 4'(i) || ALARM !== 1'b0) begin
        errors++;
        $display("FAIL default_thresh[%0d]: hit=%b count=%0d alarm=%b, expected 1 %0d 0",
                 i, HIT, COUNT, ALARM, i);
      end
      if (i == 1) begin
        checks++;
        if (alarm1 !== 1'b1 || count1 !== 4'd1) begin
          errors++;
          $display("FAIL n_hits_1: alarm=%b count=%0d, expected 1 1", alarm1, count1);
        end
      end
    end
  endtask

  task automatic test_load_same_cycle();
    step(1'b1, 1'b1, 8'h10, 1'b1, 8'h20, 1'b0);
    checks++;
    if (HIT !== 1'b1 || COUNT !== 4'd0 || ALARM !== 1'b0) begin
      errors++;
      $display("FAIL load_old_thresh: hit=%b count=%0d alarm=%b, expected 1 0 0", HIT, COUNT, ALARM);
    end
    sample(8'h20);
    checks++;
    if (HIT !== 1'b0 || COUNT !== 4'd0) begin
      errors++;
      $display("FAIL load_new_thresh: hit=%b count=%0d, expected 0 0", HIT, COUNT);
    end
  endtask

  task automatic test_trip();
    logic [7:0] vec [4];
    vec[0] = 8'h10; vec[1] = 8'h0F; vec[2] = 8'h00; vec[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      sample(vec[i]);
      checks++;
      if (HIT !== 1'b1 || COUNT !== 4'(i + 1) || ALARM !== (i == 3)) begin
        errors++;
        $display("FAIL trip[%0d]: hit=%b count=%0d alarm=%b, expected 1 %0d %b",
                 i, HIT, COUNT, ALARM, i + 1, (i == 3));
      end
    end
    sample(8'h11);
    checks++;
    if (HIT !== 1'b0 || COUNT !== 4'd4 || ALARM !== 1'b1) begin
      errors++;
      $display("FAIL tripped_miss: hit=%b count=%0d alarm=%b, expected 0 4 1", HIT, COUNT, ALARM);
    end
    step(1'b1, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0);
    checks++;
    if (HIT !== 1'b1 || COUNT !== 4'd4 || ALARM !== 1'b1) begin
      errors++;
      $display("FAIL tripped_load: hit=%b count=%0d alarm=%b, expected 1 4 1", HIT, COUNT, ALARM);
    end
    idle_cycle();
    checks++;
    if (COUNT !== 4'd4 || ALARM !== 1'b1) begin
      errors++;
      $display("FAIL tripped_hold: count=%0d alarm=%b, expected 4 1", COUNT, ALARM);
    end
  endtask

  task automatic test_ack();
    sample(8'h11);
    step(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1);
    checks++;
    if (HIT !== 1'b1 || COUNT !== 4'd0 || ALARM !== 1'b0) begin
      errors++;
      $display("FAIL ack: hit=%b count=%0d alarm=%b, expected 1 0 0", HIT, COUNT, ALARM);
    end
    sample(8'h01);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checks++;
    if (COUNT !== 4'd1 || ALARM !== 1'b0 || HIT !== 1'b1) begin
      errors++;
      $display("FAIL ack_outside: hit=%b count=%0d alarm=%b, expected 1 1 0", HIT, COUNT, ALARM);
    end
  endtask

  task automatic test_miss_and_gaps();
    sample(8'h11);
    sample(8'h01);
    idle_cycle();
    idle_cycle();
    checks++;
    if (COUNT !== 4'd1 || HIT !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold1: hit=%b count=%0d, expected 1 1", HIT, COUNT);
    end
    sample(8'h02);
    idle_cycle();
    checks++;
    if (COUNT !== 4'd2) begin
      errors++;
      $display("FAIL gap_hold2: count=%0d, expected 2", COUNT);
    end
    sample(8'h11);
    checks++;
    if (HIT !== 1'b0 || COUNT !== 4'd0 || ALARM !== 1'b0) begin
      errors++;
      $display("FAIL miss_reset: hit=%b count=%0d alarm=%b, expected 0 0 0", HIT, COUNT, ALARM);
    end
    sample(8'h01);
    checks++;
    if (COUNT !== 4'd1) begin
      errors++;
      $display("FAIL restart_from_idle: count=%0d, expected 1", COUNT);
    end
  endtask

  task automatic test_reset_tripped();
    for (int i = 0; i < 3; i++) sample(8'h00);
    checks++;
    if (ALARM !== 1'b1 || COUNT !== 4'd4) begin
      errors++;
      $display("FAIL retrip: alarm=%b count=%0d, expected 1 4", ALARM, COUNT);
    end
    step(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    checks++;
    if (ALARM !== 1'b0 || COUNT !== 4'd0 || HIT !== 1'b0) begin
      errors++;
      $display("FAIL reset_tripped: hit=%b count=%0d alarm=%b, expected 0 0 0", HIT, COUNT, ALARM);
    end
    sample(8'hFF);
    checks++;
    if (HIT !== 1'b1 || COUNT !== 4'd1) begin
      errors++;
      $display("FAIL reset_thresh: hit=%b count=%0d, expected 1 1", HIT, COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_default_thresh();
    test_load_same_cycle();
    test_trip();
    test_ack();
    test_miss_and_gaps();
    test_reset_tripped();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/threshold_monitor.md
THRESHOLD_MONITOR -- requirements
Module: threshold_monitor

Interface
REQ-001 Parameter: N_HITS, 4, consecutive qualifying samples required to trip the alarm; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESETN  input  1  reset; synchronous, active-low.
REQ-004 LOAD  input  1  load THRESH into the threshold register this cycle.
REQ-005 THRESH  input  8  unsigned threshold value, sampled only when LOAD=1.
REQ-006 VALID  input  1  DATA carries a sample this cycle.
REQ-007 DATA  input  8  unsigned sample.
REQ-008 ACK  input  1  clears a tripped alarm.
REQ-009 HIT  output  1  registered result of the last valid sample, DATA <= threshold.
REQ-010 ALARM  output  1  sticky alarm; high while the state is TRIPPED.
REQ-011 COUNT  output  4  current consecutive-hit count.

Function
REQ-012 The comparison SHALL be unsigned DATA <= threshold over 8 bits, computed as the carry-out of threshold + ~DATA + 1.
REQ-013 On a VALID cycle, HIT SHALL be updated to the compare result one cycle later; on non-VALID cycles, HIT holds.
REQ-014 The threshold register SHALL take THRESH on the edge where LOAD=1; a sample that arrives in the same cycle SHALL be compared against the old threshold.
REQ-015 States: IDLE (COUNT=0), COUNTING (0<COUNT<N_HITS), TRIPPED (COUNT=N_HITS, ALARM=1).
REQ-016 IDLE/COUNTING, VALID and hit: COUNT+1; if the result equals N_HITS, go to TRIPPED; otherwise go to or stay in COUNTING.
REQ-017 IDLE/COUNTING, VALID and miss: COUNT:=0, go to IDLE.
REQ-018 TRIPPED: COUNT saturates at N_HITS; further samples update HIT only and never change COUNT or ALARM.
REQ-019 TRIPPED and ACK=1: go to IDLE with COUNT:=0 and ALARM:=0 on the next edge; a sample in the same cycle updates HIT but is not counted.
REQ-020 ACK outside TRIPPED has no effect.
REQ-021 LOAD=1 in IDLE/COUNTING: COUNT:=0 and go to IDLE, overriding any same-cycle sample count; LOAD in TRIPPED leaves COUNT and ALARM unchanged.
REQ-022 With N_HITS=1, a single hit from IDLE SHALL trip the alarm.
REQ-023 Cycles with VALID=0 SHALL hold all state.

Reset
REQ-024 RESETN=0 at an edge SHALL set: threshold:=0xFF, HIT:=0, COUNT:=0, ALARM:=0, state:=IDLE; this overrides LOAD, VALID and ACK in that cycle.
REQ-025 Reset mid-run or while TRIPPED SHALL give the same result as REQ-024; no partial state survives.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=2'b00, COUNTING=2'b01, TRIPPED=2'b10), DATA_W=8 and CNT_W=4.
REQ-027 The compare SHALL be one combinational sub-module, ule_cmp8 (ports A, B, O = A<=B), using an inverter plus an 8-bit carry chain with CIN=1.
REQ-028 No other sub-modules; the FSM, counter and registers are in the top level.

Verification
REQ-029 Reset, then VALID DATA=0xFF for 3 cycles -> HIT=1 from cycle 2 (default threshold 0xFF); COUNT=1,2,3; ALARM=0.
REQ-030 LOAD THRESH=0x10 with VALID DATA=0x20 in the same cycle -> HIT=1 (old threshold), COUNT:=0 by LOAD; next DATA=0x20 -> HIT=0.
REQ-031 Threshold 0x10, N_HITS=4, samples 0x10,0x0F,0x00,0x10 -> COUNT 1..4, ALARM=1 after the 4th; a further 0x11 -> HIT=0, ALARM stays 1.
REQ-032 TRIPPED, ACK with VALID DATA=0x05 in the same cycle -> ALARM=0, COUNT=0, HIT=1.
REQ-033 Hits 0x01,0x02 then miss 0x11 (threshold 0x10) -> COUNT 1,2,0, state IDLE; gaps with VALID=0 in between hold COUNT.
REQ-034 RESETN=0 while TRIPPED with LOAD=1 THRESH=0x00 -> ALARM=0, COUNT=0, threshold=0xFF (DATA=0xFF then gives HIT=1).
